// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes and an
// internal accumulator that can stand in for operand B.
//
// Stage 1 captures the operand beat. Stage 2 computes the result and flags
// and holds them until the consumer takes them. Throughput is one op per
// cycle. Backpressure from out_ready propagates back to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat
//   A, B       operands (B ignored when use_acc=1)
//   opcode     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//              101 SHL, 110 SHR (logical), 111 CLEAR
//   use_acc    substitute the accumulator for B
//   out_valid  result beat valid
//   out_ready  consumer accepts the result beat
//   Result     result of the op
//   flags      {carry, overflow, zero, negative}
//   acc        accumulator (result of the most recent completed op)
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SHL   = 3'b101,
    OP_SHR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  // Stage 1 registers
  logic             s1Valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;
  logic             useAcc_q;

  // Stage 2 registers
  logic             s2Valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] acc_q;

  // Stage 2 next-state values
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;

  logic             s2Adv;
  logic             s1Load;

  logic [WIDTH-1:0] bEff;
  logic [SHW-1:0]   shAmt;
  logic [WIDTH:0]   sumWide;
  logic [WIDTH:0]   diffWide;
  logic [WIDTH:0]   shlWide;
  logic [WIDTH:0]   shrWide;
  logic             carry;
  logic             ovf;

  // S2 may take a new beat when it is empty or its current beat is leaving.
  // in_ready looks only at pipeline state and out_ready, never at in_valid.
  assign s2Adv    = s1Valid_q && (!s2Valid_q || out_ready);
  assign in_ready = !s1Valid_q || s2Adv;
  assign s1Load   = in_valid && in_ready;

  // Compute stage. The accumulator already holds the previous op's result
  // whenever the next op reaches S2, so substituting it here is hazard-free.
  // The widened shift vectors carry the last bit shifted out in their extra
  // position, which naturally reads 0 for a shift amount of zero.
  always_comb begin
    bEff     = useAcc_q ? acc_q : b_q;
    shAmt    = bEff[SHW-1:0];
    sumWide  = {1'b0, a_q} + {1'b0, bEff};
    diffWide = {1'b0, a_q} - {1'b0, bEff};
    shlWide  = {1'b0, a_q} << shAmt;
    shrWide  = {a_q, 1'b0} >> shAmt;
    result_d = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op_q)
      OP_ADD: begin
        result_d = sumWide[WIDTH-1:0];
        carry    = sumWide[WIDTH];
        ovf      = (a_q[WIDTH-1] == bEff[WIDTH-1]) &&
                   (sumWide[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = diffWide[WIDTH-1:0];
        carry    = diffWide[WIDTH];
        ovf      = (a_q[WIDTH-1] != bEff[WIDTH-1]) &&
                   (diffWide[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: result_d = a_q & bEff;
      OP_OR:  result_d = a_q | bEff;
      OP_XOR: result_d = a_q ^ bEff;
      OP_SHL: begin
        result_d = shlWide[WIDTH-1:0];
        carry    = shlWide[WIDTH];
      end
      OP_SHR: begin
        result_d = shrWide[WIDTH:1];
        carry    = shrWide[0];
      end
      default: result_d = '0;
    endcase
    flags_d = {carry, ovf, (result_d == '0), result_d[WIDTH-1]};
  end

  // Stage 1: capture the operand beat; empty out when S2 takes it and no
  // new beat arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      useAcc_q  <= 1'b0;
    end else if (s1Load) begin
      s1Valid_q <= 1'b1;
      a_q       <= A;
      b_q       <= B;
      op_q      <= op_e'(opcode);
      useAcc_q  <= use_acc;
    end else if (s2Adv) begin
      s1Valid_q <= 1'b0;
    end
  end

  // Stage 2: result, flags and accumulator only change when a beat moves
  // in, so everything holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      acc_q     <= '0;
    end else if (s2Adv) begin
      s2Valid_q <= 1'b1;
      result_q  <= result_d;
      flags_q   <= flags_d;
      acc_q     <= result_d;
    end else if (out_ready) begin
      s2Valid_q <= 1'b0;
    end
  end

  assign out_valid = s2Valid_q;
  assign Result    = result_q;
  assign flags     = flags_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- self-checking bench for alu_pipe. A WIDTH=4 and a WIDTH=8
// instance share all inputs and run in lockstep; each has its own reference
// accumulator and expected-result queue, filled from an arithmetic model at
// the moment a beat is accepted and drained as result beats are taken.
module tb_alu_pipe;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3;
  localparam int OP_XOR = 4, OP_SHL = 5, OP_SHR = 6, OP_CLR = 7;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       outReady;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic [2:0] opIn;
  logic       useAcc;

  logic       inReady4, outValid4;
  logic [3:0] result4, flags4, acc4;
  logic       inReady8, outValid8;
  logic [7:0] result8, acc8;
  logic [3:0] flags8;

  int checks = 0;
  int errors = 0;

  int q4Res[$], q4Fl[$], q8Res[$], q8Fl[$];
  int acc4M, acc8M;
  int last4Res, last4Fl, last8Res, last8Fl;
  int popCount8 = 0;
  bit prevHold8 = 0;
  logic [7:0] prevRes8;
  logic [3:0] prevFl8;

  alu_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady4),
    .A(aIn[3:0]), .B(bIn[3:0]), .opcode(opIn), .use_acc(useAcc),
    .out_valid(outValid4), .out_ready(outReady), .Result(result4),
    .flags(flags4), .acc(acc4)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady8),
    .A(aIn), .B(bIn), .opcode(opIn), .use_acc(useAcc),
    .out_valid(outValid8), .out_ready(outReady), .Result(result8),
    .flags(flags8), .acc(acc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: operands as plain integers, flags from the rules.
  // Shift amount is b mod w (the low log2(w) bits for power-of-two widths).
  function automatic void refOp(input int w, input int op, input int a,
                                input int b, output int res, output int fl);
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int sa, sb, sr, sh;
    int c = 0;
    int v = 0;
    a = a & mask;
    b = b & mask;
    sh = b % w;
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    res = 0;
    case (op)
      OP_ADD: begin
        res = a + b;
        c = (res > mask) ? 1 : 0;
        sr = sa + sb;
        v = (sr < -half || sr >= half) ? 1 : 0;
      end
      OP_SUB: begin
        res = a - b;
        c = (a < b) ? 1 : 0;
        sr = sa - sb;
        v = (sr < -half || sr >= half) ? 1 : 0;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res = a << sh;
        c = (sh == 0) ? 0 : ((a >> (w - sh)) & 1);
      end
      OP_SHR: begin
        res = a >> sh;
        c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
      end
      default: res = 0;
    endcase
    res = res & mask;
    fl = (c ? 8 : 0) + (v ? 4 : 0) + ((res == 0) ? 2 : 0) +
         (((res >> (w - 1)) & 1) != 0 ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic popCheck4();
    int r, f;
    chk("sb4_pending", 32'(q4Res.size() > 0), 32'd1);
    if (q4Res.size() > 0) begin
      r = q4Res.pop_front();
      f = q4Fl.pop_front();
      chk("w4_result", 32'(result4), r);
      chk("w4_flags", 32'(flags4), f);
      chk("w4_acc", 32'(acc4), r);
      last4Res = 32'(result4);
      last4Fl  = 32'(flags4);
    end
  endtask

  task automatic popCheck8();
    int r, f;
    chk("sb8_pending", 32'(q8Res.size() > 0), 32'd1);
    if (q8Res.size() > 0) begin
      r = q8Res.pop_front();
      f = q8Fl.pop_front();
      chk("w8_result", 32'(result8), r);
      chk("w8_flags", 32'(flags8), f);
      chk("w8_acc", 32'(acc8), r);
      last8Res = 32'(result8);
      last8Fl  = 32'(flags8);
      popCount8++;
    end
  endtask

  // One clock: sample handshakes on the falling edge, then step past the
  // rising edge so the caller can drive the next inputs.
  task automatic cycle(output bit accepted);
    int r, f;
    @(negedge clk);
    if (prevHold8) begin
      chk("hold_valid", 32'(outValid8), 32'd1);
      chk("hold_result", 32'(result8), 32'(prevRes8));
      chk("hold_flags", 32'(flags8), 32'(prevFl8));
    end
    accepted = inValid && inReady8;
    if (accepted) begin
      refOp(4, int'(opIn), int'(aIn), useAcc ? acc4M : int'(bIn), r, f);
      q4Res.push_back(r); q4Fl.push_back(f); acc4M = r;
      refOp(8, int'(opIn), int'(aIn), useAcc ? acc8M : int'(bIn), r, f);
      q8Res.push_back(r); q8Fl.push_back(f); acc8M = r;
    end
    if (outValid4 && outReady) popCheck4();
    if (outValid8 && outReady) popCheck8();
    prevHold8 = outValid8 && !outReady;
    prevRes8  = result8;
    prevFl8   = flags8;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int op, input int a, input int b,
                               input bit ua, output int waited);
    bit got = 0;
    waited = 0;
    opIn = 3'(op); aIn = 8'(a); bIn = 8'(b); useAcc = ua;
    inValid = 1'b1;
    while (!got && waited < 20) begin
      cycle(got);
      waited++;
    end
    chk("accept_in_time", 32'(got), 32'd1);
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bit got;
    inValid = 1'b0;
    while ((q4Res.size() > 0 || q8Res.size() > 0) && n < 50) begin
      cycle(got);
      n++;
    end
    chk("drain_in_time", 32'(n < 50), 32'd1);
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    chk(tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w, base, r8;
    bit got;
    rst_n = 1'b1; inValid = 1'b0; outReady = 1'b1;
    aIn = '0; bIn = '0; opIn = '0; useAcc = 1'b0;
    acc4M = 0; acc8M = 0;

    // Reset values, asynchronously
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", int'(outValid8), 0);
    checkOutput("rst_result", int'(result8), 0);
    checkOutput("rst_flags", int'(flags8), 0);
    checkOutput("rst_acc", int'(acc8), 0);
    checkOutput("rst_out_valid4", int'(outValid4), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready_after_reset", int'(inReady8), 1);

    // Latency: valid after the edge following the accepting edge
    opIn = 3'(OP_ADD); aIn = 8'h05; bIn = 8'h03; useAcc = 1'b0;
    inValid = 1'b1;
    cycle(got);
    checkOutput("lat_accept", int'(got), 1);
    inValid = 1'b0;
    checkOutput("lat_not_yet", int'(outValid8), 0);
    @(posedge clk); #1;
    checkOutput("lat_valid", int'(outValid8), 1);
    drain();
    checkOutput("w4_add_5_3_res", last4Res, 8);
    checkOutput("w4_add_5_3_flags", last4Fl, 5);

    applyStimulus(OP_SUB, 2, 5, 0, w); drain();
    checkOutput("w4_sub_res", last4Res, 13);
    checkOutput("w4_sub_flags", last4Fl, 9);
    applyStimulus(OP_ADD, 7, 1, 0, w); drain();
    checkOutput("w4_add_ovf_res", last4Res, 8);
    checkOutput("w4_add_ovf_flags", last4Fl, 5);
    applyStimulus(OP_ADD, 15, 1, 0, w); drain();
    checkOutput("w4_add_carry_res", last4Res, 0);
    checkOutput("w4_add_carry_flags", last4Fl, 10);

    applyStimulus(OP_AND, 8'hCC, 8'hAA, 0, w); drain();
    checkOutput("w8_and", last8Res, 8'h88);
    applyStimulus(OP_OR, 8'hCC, 8'hAA, 0, w); drain();
    checkOutput("w8_or", last8Res, 8'hEE);
    applyStimulus(OP_XOR, 8'hCC, 8'hAA, 0, w); drain();
    checkOutput("w8_xor", last8Res, 8'h66);
    checkOutput("w8_xor_flags", last8Fl, 0);
    applyStimulus(OP_SHL, 8'h81, 1, 0, w); drain();
    checkOutput("w8_shl_res", last8Res, 8'h02);
    checkOutput("w8_shl_flags", last8Fl, 8);
    applyStimulus(OP_SHR, 8'h81, 1, 0, w); drain();
    checkOutput("w8_shr_res", last8Res, 8'h40);
    checkOutput("w8_shr_flags", last8Fl, 8);
    applyStimulus(OP_CLR, 8'h5A, 8'h3C, 0, w); drain();
    checkOutput("w8_clear_res", last8Res, 0);
    checkOutput("w8_clear_flags", last8Fl, 2);
    checkOutput("w8_clear_acc", int'(acc8), 0);

    // Accumulator chain, issued back-to-back
    applyStimulus(OP_ADD, 5, 3, 0, w);
    checkOutput("chain_b2b_0", w, 1);
    applyStimulus(OP_ADD, 10, 0, 1, w);
    checkOutput("chain_b2b_1", w, 1);
    applyStimulus(OP_SUB, 1, 0, 1, w);
    checkOutput("chain_b2b_2", w, 1);
    drain();
    checkOutput("chain_res", last8Res, 8'hEF);
    checkOutput("chain_acc", int'(acc8), 8'hEF);
    checkOutput("chain_acc4", int'(acc4), 4'hF);

    // Backpressure: four ADDs with the consumer stalled
    base = popCount8;
    outReady = 1'b0;
    applyStimulus(OP_ADD, 8'h10, 8'h01, 0, w);
    applyStimulus(OP_ADD, 8'h20, 8'h02, 0, w);
    opIn = 3'(OP_ADD); aIn = 8'h30; bIn = 8'h03; useAcc = 1'b0;
    inValid = 1'b1;
    cycle(got);
    checkOutput("bp_in_ready_drop", int'(got), 0);
    r8 = int'(result8);
    for (int i = 0; i < 5; i++) begin
      cycle(got);
      checkOutput("bp_blocked", int'(got), 0);
      checkOutput("bp_result_stable", int'(result8), r8);
    end
    outReady = 1'b1;
    for (int i = 0; i < 10 && !got; i++) cycle(got);
    checkOutput("bp_third_accepted", int'(got), 1);
    applyStimulus(OP_ADD, 8'h40, 8'h04, 0, w);
    drain();
    checkOutput("bp_count", popCount8 - base, 4);
    checkOutput("bp_last", last8Res, 8'h44);

    // Randomized traffic with random stalls
    got = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!inValid || got) begin
        opIn = 3'($urandom_range(0, 7));
        aIn = 8'($urandom);
        bIn = 8'($urandom);
        useAcc = 1'($urandom_range(0, 1));
      end
      inValid = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      cycle(got);
    end
    outReady = 1'b1;
    drain();
    checkOutput("idle_after_random", int'(outValid8), 0);

    // Reset with two beats in flight
    outReady = 1'b0;
    applyStimulus(OP_ADD, 8'h11, 8'h22, 0, w);
    applyStimulus(OP_ADD, 8'h30, 8'h01, 0, w);
    checkOutput("pre_reset_busy", int'(outValid8), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(outValid8), 0);
    checkOutput("mid_rst_result", int'(result8), 0);
    checkOutput("mid_rst_flags", int'(flags8), 0);
    checkOutput("mid_rst_acc", int'(acc8), 0);
    checkOutput("mid_rst_acc4", int'(acc4), 0);
    q4Res.delete(); q4Fl.delete(); q8Res.delete(); q8Fl.delete();
    acc4M = 0; acc8M = 0; prevHold8 = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b1;
    applyStimulus(OP_ADD, 8'h21, 8'h99, 1, w);
    drain();
    checkOutput("post_rst_res", last8Res, 8'h21);
    checkOutput("post_rst_res4", last4Res, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
